// File: rtl/ticsat_cmd_sequencer.sv
// Command sequencer for an N x N systolic array: per job it loads weights,
// fills the skew queue, then streams M vectors plus N-1 drain cycles.
module ticsat_cmd_sequencer #(
  parameter int N     = 8,
  parameter int LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start_valid,
  output logic             o_start_ready,
  input  logic [LEN_W-1:0] i_start_len,
  input  logic             i_start_reuse_w,
  input  logic             i_feed_valid,
  output logic [1:0]       o_cmd,
  output logic             o_out_valid,
  output logic             o_busy,
  output logic             o_done
);

  // One extra bit beyond LEN_W + log2(N) so M + N - 1 never wraps.
  localparam int CNT_W = LEN_W + $clog2(N) + 1;

  localparam logic [1:0] CMD_WRITE  = 2'b00;
  localparam logic [1:0] CMD_QUEUE  = 2'b01;
  localparam logic [1:0] CMD_STREAM = 2'b10;
  localparam logic [1:0] CMD_NONE   = 2'b11;

  localparam logic [CNT_W-1:0] W_NM1 = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] W_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WEIGHTS,
    S_QUEUE,
    S_STREAM,
    S_DONE
  } state_t;

  // A 1x1 array has no skew to fill, so the queue phase disappears.
  localparam state_t S_AFTER_W = (N > 1) ? S_QUEUE : S_STREAM;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_weights_loaded;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_len_ext;
  logic             w_accept;
  logic             w_set_loaded;
  logic             w_issue;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_len            <= '0;
      r_weights_loaded <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_len <= i_start_len;
      end
      if (w_set_loaded) begin
        r_weights_loaded <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_accept      = 1'b0;
    w_set_loaded  = 1'b0;
    w_issue       = 1'b0;
    w_cnt_inc     = r_cnt + W_ONE;
    w_len_ext     = {{(CNT_W - LEN_W){1'b0}}, r_len};
    o_cmd         = CMD_NONE;
    o_out_valid   = 1'b0;
    o_done        = 1'b0;
    o_start_ready = (r_state == S_IDLE);
    o_busy        = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (i_start_valid) begin
          w_accept  = 1'b1;
          w_cnt_nxt = '0;
          if (i_start_reuse_w && r_weights_loaded) begin
            w_state_nxt = (i_start_len == '0) ? S_DONE : S_AFTER_W;
          end else begin
            w_state_nxt = S_WEIGHTS;
          end
        end
      end

      S_WEIGHTS: begin
        if (i_feed_valid) begin
          o_cmd = CMD_WRITE;
          if (r_cnt == W_NM1) begin
            w_set_loaded = 1'b1;
            w_cnt_nxt    = '0;
            w_state_nxt  = (r_len == '0) ? S_DONE : S_AFTER_W;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end

      S_QUEUE: begin
        if (i_feed_valid) begin
          o_cmd = CMD_QUEUE;
          if (w_cnt_inc == W_NM1) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_STREAM;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end

      S_STREAM: begin
        // Drain cycles (index >= M) only flush the array and never wait on data.
        w_issue = i_feed_valid || (r_cnt >= w_len_ext);
        if (w_issue) begin
          o_cmd       = CMD_STREAM;
          o_out_valid = (r_cnt >= W_NM1);
          if (w_cnt_inc == (w_len_ext + W_NM1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end

      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ticsat_cmd_sequencer.sv
// Self-checking bench for ticsat_cmd_sequencer: directed timing scenarios plus
// randomized jobs, all compared every cycle against an issued-count job model.
module tb_ticsat_cmd_sequencer;

  localparam int N     = 4;
  localparam int LEN_W = 16;

  logic             clk;
  logic             i_rst;
  logic             i_start_valid;
  logic             o_start_ready;
  logic [LEN_W-1:0] i_start_len;
  logic             i_start_reuse_w;
  logic             i_feed_valid;
  logic [1:0]       o_cmd;
  logic             o_out_valid;
  logic             o_busy;
  logic             o_done;

  int checks = 0;
  int errors = 0;

  ticsat_cmd_sequencer #(.N(N), .LEN_W(LEN_W)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_start_valid  (i_start_valid),
    .o_start_ready  (o_start_ready),
    .i_start_len    (i_start_len),
    .i_start_reuse_w(i_start_reuse_w),
    .i_feed_valid   (i_feed_valid),
    .o_cmd          (o_cmd),
    .o_out_valid    (o_out_valid),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit valid, input int len, input bit reuse, input bit feed);
    @(posedge clk);
    #1;
    i_start_valid   = valid;
    i_start_len     = LEN_W'(len);
    i_start_reuse_w = reuse;
    i_feed_valid    = feed;
  endtask

  // Job model: a job is a count of issued command cycles. The first W are
  // weight writes, the next N-1 queue fills, then M feed and N-1 drain streams.
  bit mKnown  = 0;
  bit mActive = 0;
  bit mDone   = 0;
  bit mLoaded = 0;
  int mK, mW, mM, mTotal;

  always @(negedge clk) begin
    int code, s;
    bit stall, ovPhase, issue;
    int eCmd, eOv, eReady, eBusy, eDone;
    issue = 0;
    if (mKnown) begin
      eReady = (!mActive && !mDone) ? 1 : 0;
      eBusy  = 1 - eReady;
      eDone  = mDone ? 1 : 0;
      eCmd   = 3;
      eOv    = 0;
      if (mActive) begin
        ovPhase = 0;
        if (mK < mW) begin
          code = 0; stall = 1;
        end else if (mK < mW + N - 1) begin
          code = 1; stall = 1;
        end else begin
          s       = mK - mW - (N - 1);
          code    = 2;
          stall   = (s < mM);
          ovPhase = (s >= N - 1);
        end
        issue = !stall || i_feed_valid;
        if (issue) begin
          eCmd = code;
          eOv  = ovPhase ? 1 : 0;
        end
      end
      checkOutput("cmd", int'(o_cmd), eCmd);
      checkOutput("out_valid", int'(o_out_valid), eOv);
      checkOutput("busy", int'(o_busy), eBusy);
      checkOutput("done", int'(o_done), eDone);
      checkOutput("start_ready", int'(o_start_ready), eReady);
    end
    if (i_rst) begin
      mKnown  = 1;
      mActive = 0;
      mDone   = 0;
      mLoaded = 0;
      mK      = 0;
    end else if (mKnown) begin
      if (mDone) begin
        mDone = 0;
      end else if (mActive) begin
        if (issue) begin
          mK++;
          if (mW == N && mK == N) mLoaded = 1;
          if (mK == mTotal) begin
            mActive = 0;
            mDone   = 1;
          end
        end
      end else if (i_start_valid) begin
        mM     = int'(i_start_len);
        mW     = (i_start_reuse_w && mLoaded) ? 0 : N;
        mK     = 0;
        mTotal = (mM == 0) ? mW : mW + 2 * (N - 1) + mM;
        if (mTotal == 0) mDone = 1;
        else mActive = 1;
      end
    end
  end

  // Per-job event log, offsets relative to the accept cycle.
  int cyc = 0;
  int tAcc = 0;
  int n00, n01, n10, nOv, nStall;
  int first00, first01, first10, firstOv, doneOff;

  always @(negedge clk) begin
    int rel;
    cyc++;
    if (!i_rst && i_start_valid && o_start_ready) begin
      tAcc = cyc;
      n00 = 0; n01 = 0; n10 = 0; nOv = 0; nStall = 0;
      first00 = -1; first01 = -1; first10 = -1; firstOv = -1; doneOff = -1;
    end else if (o_busy) begin
      rel = cyc - tAcc;
      case (o_cmd)
        2'b00: begin n00++; if (first00 < 0) first00 = rel; end
        2'b01: begin n01++; if (first01 < 0) first01 = rel; end
        2'b10: begin n10++; if (first10 < 0) first10 = rel; end
        default: if (!o_done) nStall++;
      endcase
      if (o_out_valid) begin
        nOv++;
        if (firstOv < 0) firstOv = rel;
      end
      if (o_done) doneOff = rel;
    end
  end

  // mode 0: feed always high; mode 1: random feed and random ignored starts;
  // mode 2: feed low on offsets 6, 7 (queue) and 14 (drain).
  task automatic runJob(input int len, input bit reuse, input int mode, input int abortAt);
    int cycles;
    bit seenDone, aborted;
    applyStimulus(1'b1, len, reuse, 1'b1);
    cycles = 0; seenDone = 0; aborted = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (mode == 1) begin
        i_start_valid   = ($urandom_range(0, 1) == 1);
        i_start_len     = LEN_W'($urandom_range(0, 9));
        i_start_reuse_w = ($urandom_range(0, 1) == 1);
        i_feed_valid    = ($urandom_range(0, 3) != 0);
      end else begin
        i_start_valid = 1'b0;
        i_feed_valid  = (mode == 2) ? !(cycles == 6 || cycles == 7 || cycles == 14) : 1'b1;
      end
      if (abortAt != 0 && cycles == abortAt) begin
        i_rst   = 1'b1;
        aborted = 1;
      end
      @(negedge clk);
      if (o_done) seenDone = 1;
    end while (!seenDone && !aborted && cycles < 400);
    if (!seenDone && !aborted) checkOutput("job_timeout", 0, 1);
    @(posedge clk);
    #1;
    i_rst         = 1'b0;
    i_start_valid = 1'b0;
    i_feed_valid  = 1'b1;
  endtask

  initial begin
    i_rst           = 1'b1;
    i_start_valid   = 1'b0;
    i_start_len     = '0;
    i_start_reuse_w = 1'b0;
    i_feed_valid    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_cmd", int'(o_cmd), 3);
    checkOutput("reset_busy", int'(o_busy), 0);
    checkOutput("reset_done", int'(o_done), 0);
    checkOutput("reset_start_ready", int'(o_start_ready), 1);

    runJob(3, 1'b1, 0, 0);
    checkOutput("reuse_after_reset_writes", n00, 4);
    checkOutput("reuse_after_reset_queue", n01, 3);

    runJob(3, 1'b0, 0, 0);
    checkOutput("basic_first_write", first00, 1);
    checkOutput("basic_first_queue", first01, 5);
    checkOutput("basic_first_stream", first10, 8);
    checkOutput("basic_stream_cycles", n10, 6);
    checkOutput("basic_first_out_valid", firstOv, 11);
    checkOutput("basic_out_valid_count", nOv, 3);
    checkOutput("basic_done_offset", doneOff, 14);
    @(negedge clk);
    checkOutput("basic_ready_after_done", int'(o_start_ready), 1);

    runJob(3, 1'b0, 2, 0);
    checkOutput("stall_queue_cycles", n01, 3);
    checkOutput("stall_idle_cycles", nStall, 2);
    checkOutput("stall_first_stream", first10, 10);
    checkOutput("stall_first_out_valid", firstOv, 13);
    checkOutput("stall_done_offset", doneOff, 16);

    runJob(3, 1'b1, 0, 0);
    checkOutput("reuse_writes", n00, 0);
    checkOutput("reuse_first_queue", first01, 1);

    runJob(0, 1'b0, 0, 0);
    checkOutput("empty_writes", n00, 4);
    checkOutput("empty_queue", n01, 0);
    checkOutput("empty_stream", n10, 0);
    checkOutput("empty_out_valid", nOv, 0);
    checkOutput("empty_done_offset", doneOff, 5);

    runJob(5, 1'b0, 0, 9);
    @(negedge clk);
    checkOutput("abort_cmd", int'(o_cmd), 3);
    checkOutput("abort_busy", int'(o_busy), 0);
    checkOutput("abort_done", int'(o_done), 0);
    checkOutput("abort_no_done_pulse", doneOff, -1);

    runJob(2, 1'b1, 0, 0);
    checkOutput("reuse_after_abort_writes", n00, 4);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 0, 1'b0, ($urandom_range(0, 1) == 1));
      runJob($urandom_range(0, 6), ($urandom_range(0, 1) == 1), 1,
             ($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : 0);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
